// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned UART_FRAME_BITS = 10;

  // Wrap a rotated index back into 0..n-1; v never exceeds 2*n-1 here.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set bit of i_req after i_ptr, wrapping.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan ptr+1, ptr+2, ... so the last winner has the lowest priority.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      logic [IDX_W-1:0] w_cand;
      w_cand = IDX_W'(rr_wrap(32'(i_ptr) + k, NUM_REQ));
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional WAIT-state watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned NUM_CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_CLKS     = 2 * UART_FRAME_BITS * NUM_CLKS_PER_BIT,
  localparam int unsigned ID_W            = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_din,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_timeout_err
);

  arb_state_t      r_state, w_state_next;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_grant_id;
  logic [7:0]      r_tx_din;
  logic            w_pick_found;
  logic [ID_W-1:0] w_pick_idx;
  logic            w_accept;
  logic            w_timeout;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  // Ready is only offered in IDLE, so any pick there is a completed handshake.
  assign w_accept = (r_state == IDLE) && w_pick_found && !i_rst;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  assign w_timeout = (r_state == WAIT) && !i_tx_done &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CLKS - 1));

  // WAIT cycle counter (zero outside WAIT) and registered timeout pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;

  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
  assign w_unused_cfg  = ^32'(TIMEOUT_CLKS);
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; tx_done only matters in WAIT.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = START;
      START:   w_state_next = WAIT;
      WAIT:    if (i_tx_done || w_timeout) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: ready to the winner in IDLE, start pulse in START.
  always_comb begin
    o_req_ready = '0;
    o_tx_start  = 1'b0;
    o_busy      = 1'b0;
    unique case (r_state)
      IDLE:  if (w_accept) o_req_ready[w_pick_idx] = 1'b1;
      START: begin
        o_tx_start = 1'b1;
        o_busy     = 1'b1;
      end
      WAIT:    o_busy = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

  // Latch the granted byte and id; the pointer follows the winner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_din   <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_tx_din   <= i_req_data[{w_pick_idx, 3'b000} +: 8];
      r_grant_id <= w_pick_idx;
      r_rr_ptr   <= w_pick_idx;
    end
  end

  assign o_tx_din   = r_tx_din;
  assign o_grant_id = r_grant_id;

endmodule
